// File: rtl/miriscv_gpr_file.sv
// RV32IM general-purpose register file with a busy-bit scoreboard for long-latency results.
// Combinational read ports with optional same-cycle forwarding; x0 is hardwired to zero.
module miriscv_gpr_file #(
    parameter int GPR_ADDR_W   = 5,
    parameter int XLEN         = 32,
    parameter int NUM_RD_PORTS = 2,
    parameter bit BYPASS_EN    = 1'b1,
    parameter bit RESET_GPRS   = 1'b1
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic [NUM_RD_PORTS*GPR_ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]         rd_data_o,
    output logic [NUM_RD_PORTS-1:0]              rd_busy_o,
    input  logic                                 wr_en_i,
    input  logic [GPR_ADDR_W-1:0]                wr_addr_i,
    input  logic [XLEN-1:0]                      wr_data_i,
    input  logic                                 res_en_i,
    input  logic [GPR_ADDR_W-1:0]                res_addr_i,
    input  logic                                 lwb_en_i,
    input  logic [GPR_ADDR_W-1:0]                lwb_addr_i,
    input  logic [XLEN-1:0]                      lwb_data_i,
    output logic [GPR_ADDR_W:0]                  busy_cnt_o,
    output logic                                 stray_wb_o
);

    localparam int NREGS = 2 ** GPR_ADDR_W;

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [XLEN-1:0]       w_regs_next [NREGS];
    logic [NREGS-1:0]      r_busy;
    logic [NREGS-1:0]      w_busy_next;
    logic [GPR_ADDR_W:0]   r_busy_cnt;
    logic [GPR_ADDR_W:0]   w_busy_pop;
    logic                  r_stray;
    logic                  w_stray;

    // Writes and reservations to x0 are dropped up front so no later logic sees them.
    logic w_wr_en;
    logic w_res_en;
    logic w_lwb_en;

    assign w_wr_en  = wr_en_i  && (wr_addr_i  != '0);
    assign w_res_en = res_en_i && (res_addr_i != '0);
    assign w_lwb_en = lwb_en_i && (lwb_addr_i != '0);

    // Per-register next state: wr port beats lwb for data; reservation beats lwb for busy.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign w_regs_next[gi] = '0;
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_xn
                logic w_wr_hit;
                logic w_lwb_hit;
                logic w_res_hit;

                assign w_wr_hit  = w_wr_en  && (wr_addr_i  == GPR_ADDR_W'(gi));
                assign w_lwb_hit = w_lwb_en && (lwb_addr_i == GPR_ADDR_W'(gi));
                assign w_res_hit = w_res_en && (res_addr_i == GPR_ADDR_W'(gi));

                assign w_regs_next[gi] = w_wr_hit  ? wr_data_i  :
                                         w_lwb_hit ? lwb_data_i :
                                                     r_regs[gi];
                assign w_busy_next[gi] = w_res_hit ? 1'b1 :
                                         w_lwb_hit ? 1'b0 :
                                                     r_busy[gi];
            end
        end
    endgenerate

    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_busy_pop = w_busy_pop + {{GPR_ADDR_W{1'b0}}, r_busy[i]};
        end
    end

    assign w_stray = w_lwb_en && !r_busy[lwb_addr_i];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREGS; i++) begin
            if (!rstn_i) begin
                if (RESET_GPRS) begin
                    r_regs[i] <= '0;
                end
            end else begin
                r_regs[i] <= w_regs_next[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_stray    <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_busy_cnt <= w_busy_pop;
            r_stray    <= w_stray;
        end
    end

    assign busy_cnt_o = r_busy_cnt;
    assign stray_wb_o = r_stray;

    // Read ports: forwarding makes a result usable by decode in the cycle it is written back.
    generate
        for (genvar gi = 0; gi < NUM_RD_PORTS; gi++) begin : g_rd
            logic [GPR_ADDR_W-1:0] w_addr;
            logic [XLEN-1:0]       w_data;
            logic                  w_busy;
            logic                  w_fwd_wr;
            logic                  w_fwd_lwb;

            assign w_addr    = rd_addr_i[gi*GPR_ADDR_W +: GPR_ADDR_W];
            assign w_fwd_wr  = BYPASS_EN && w_wr_en  && (wr_addr_i  == w_addr);
            assign w_fwd_lwb = BYPASS_EN && w_lwb_en && (lwb_addr_i == w_addr);

            always_comb begin
                w_data = r_regs[w_addr];
                w_busy = r_busy[w_addr];
                if (w_addr == '0) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end else begin
                    if (w_fwd_wr) begin
                        w_data = wr_data_i;
                    end else if (w_fwd_lwb) begin
                        w_data = lwb_data_i;
                    end
                    if (w_fwd_lwb) begin
                        w_busy = 1'b0;
                    end
                end
            end

            assign rd_data_o[gi*XLEN +: XLEN] = w_data;
            assign rd_busy_o[gi]              = w_busy;
        end
    endgenerate

endmodule
